// File: rtl/pll_rst_seq_pkg.sv
// rtl/pll_rst_seq_pkg.sv - shared types and sizing helpers for the PLL lock/reset sequencer
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RELEASE,
    RUN
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  // Width of the shared phase counter: it must hold the largest terminal count of any phase.
  function automatic int cnt_width(input int rst_cycles, input int timeout,
                                   input int stable_cycles, input int release_span);
    int m;
    m = rst_cycles;
    if (timeout > m) m = timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (release_span > m) m = release_span;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-stage flop chain bringing an asynchronous status bit into the clk domain
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// rtl/pll_lock_reset_sequencer.sv - resets the PLL until it locks, then releases domain resets in stages
module pll_lock_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int NUM_DOMAINS    = 3,
  parameter int STAGE_GAP      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked_async,
  input  logic                   sw_pll_reset,
  input  logic                   clr_cnt,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_released,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                (NUM_DOMAINS - 1) * STAGE_GAP + 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_DOMAINS - 1) * STAGE_GAP);

  seq_state_t      state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            lock_s;
  logic            loss;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_locked_async),
    .q  (lock_s)
  );

  // Only a drop after release has started counts as a loss; drops while stabilizing just restart.
  assign loss    = !lock_s && ((state == RELEASE) || (state == RUN));
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PLL_RESET;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      domain_rst    <= '1;
      all_released  <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      if (clr_cnt) begin
        lock_loss_cnt <= '0;
      end else if (loss && (lock_loss_cnt != '1)) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end

      if (sw_pll_reset && (state != PLL_RESET)) begin
        state        <= PLL_RESET;
        cnt          <= '0;
        pll_rst      <= 1'b1;
        domain_rst   <= '1;
        all_released <= 1'b0;
      end else begin
        case (state)
          PLL_RESET: begin
            if (cnt == RST_LAST) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end

          WAIT_LOCK: begin
            if (lock_s) begin
              state <= STABILIZE;
              cnt   <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              state   <= PLL_RESET;
              cnt     <= '0;
              pll_rst <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end

          STABILIZE: begin
            if (!lock_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              cnt           <= '0;
              domain_rst[0] <= 1'b0;
              if (NUM_DOMAINS == 1) begin
                state        <= RUN;
                all_released <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end

          RELEASE: begin
            if (!lock_s) begin
              state        <= WAIT_LOCK;
              cnt          <= '0;
              domain_rst   <= '1;
              all_released <= 1'b0;
            end else begin
              cnt <= cnt_inc;
              for (int i = 1; i < NUM_DOMAINS; i++) begin
                if (cnt_inc == CW'(i * STAGE_GAP)) begin
                  domain_rst[i] <= 1'b0;
                end
              end
              if (cnt_inc == RELEASE_LAST) begin
                state        <= RUN;
                all_released <= 1'b1;
              end
            end
          end

          RUN: begin
            if (!lock_s) begin
              state        <= WAIT_LOCK;
              cnt          <= '0;
              domain_rst   <= '1;
              all_released <= 1'b0;
            end
          end

          default: begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst   <= '1;
            all_released <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb/tb_pll_lock_reset_sequencer.sv - directed self-checking bench for pll_lock_reset_sequencer
module tb_pll_lock_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked_async;
  logic       sw_pll_reset;
  logic       clr_cnt;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       all_released;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  pll_lock_reset_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .NUM_DOMAINS   (3),
    .STAGE_GAP     (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked_async(pll_locked_async),
    .sw_pll_reset    (sw_pll_reset),
    .clr_cnt         (clr_cnt),
    .pll_rst         (pll_rst),
    .domain_rst      (domain_rst),
    .all_released    (all_released),
    .lock_loss_cnt   (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked_async = 1'b0;
    sw_pll_reset = 1'b0;
    clr_cnt = 1'b0;
    step(3);
    checks++;
    if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    checks++;
    if (domain_rst !== 3'b111) begin failures++; $display("FAIL reset_domain got=%b exp=111", domain_rst); end
    checks++;
    if (all_released !== 1'b0) begin failures++; $display("FAIL reset_all_released got=%b exp=0", all_released); end
    checks++;
    if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL reset_loss_cnt got=%0d exp=0", lock_loss_cnt); end
  endtask

  task automatic test_staged_release();
    logic [2:0] exp_dom;
    pll_locked_async = 1'b0;
    apply_reset();
    for (int e = 1; e <= 10; e++) begin
      step(1);
      checks++;
      if (pll_rst !== (e < 4)) begin
        failures++;
        $display("FAIL release_pll_rst edge=%0d got=%b exp=%b", e, pll_rst, (e < 4));
      end
    end
    pll_locked_async = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      exp_dom = (k < 11) ? 3'b111 : (k < 13) ? 3'b110 : (k < 15) ? 3'b100 : 3'b000;
      checks++;
      if (domain_rst !== exp_dom || all_released !== (k >= 15)) begin
        failures++;
        $display("FAIL release_dom edge=%0d got=%b/%b exp=%b/%b", k, domain_rst, all_released, exp_dom, (k >= 15));
      end
    end
  endtask

  task automatic test_lock_timeout();
    logic exp_rst;
    pll_locked_async = 1'b0;
    apply_reset();
    for (int e = 1; e <= 100; e++) begin
      step(1);
      exp_rst = (e < 4) ? 1'b1 : (((e - 4) % 36) >= 32);
      checks++;
      if (pll_rst !== exp_rst || domain_rst !== 3'b111 || lock_loss_cnt !== 8'd0) begin
        failures++;
        $display("FAIL timeout edge=%0d got=%b/%b/%0d exp=%b/111/0", e, pll_rst, domain_rst, lock_loss_cnt, exp_rst);
      end
    end
  endtask

  task automatic test_stabilize_glitch();
    logic [2:0] exp_dom;
    pll_locked_async = 1'b0;
    apply_reset();
    step(10);
    pll_locked_async = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      step(1);
      if (k == 7) pll_locked_async = 1'b0;
      if (k == 8) pll_locked_async = 1'b1;
      exp_dom = (k < 19) ? 3'b111 : (k < 21) ? 3'b110 : (k < 23) ? 3'b100 : 3'b000;
      checks++;
      if (domain_rst !== exp_dom || lock_loss_cnt !== 8'd0) begin
        failures++;
        $display("FAIL glitch edge=%0d got=%b/%0d exp=%b/0", k, domain_rst, lock_loss_cnt, exp_dom);
      end
    end
  endtask

  task automatic test_lock_loss_run();
    logic [2:0] exp_dom;
    pll_locked_async = 1'b0;
    step(2);
    checks++;
    if (domain_rst !== 3'b000) begin failures++; $display("FAIL loss_early got=%b exp=000", domain_rst); end
    step(1);
    checks++;
    if (domain_rst !== 3'b111 || all_released !== 1'b0) begin
      failures++;
      $display("FAIL loss_reset got=%b/%b exp=111/0", domain_rst, all_released);
    end
    checks++;
    if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL loss_count got=%0d exp=1", lock_loss_cnt); end
    pll_locked_async = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      exp_dom = (k < 11) ? 3'b111 : (k < 13) ? 3'b110 : (k < 15) ? 3'b100 : 3'b000;
      checks++;
      if (domain_rst !== exp_dom || all_released !== (k >= 15)) begin
        failures++;
        $display("FAIL relock_dom edge=%0d got=%b/%b exp=%b/%b", k, domain_rst, all_released, exp_dom, (k >= 15));
      end
    end
  endtask

  task automatic test_saturation_and_clear();
    int exp_loss;
    exp_loss = 1;
    for (int n = 1; n <= 300; n++) begin
      pll_locked_async = 1'b0;
      step(3);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      checks++;
      if (lock_loss_cnt !== 8'(exp_loss)) begin
        failures++;
        $display("FAIL sat_count loss=%0d got=%0d exp=%0d", n, lock_loss_cnt, exp_loss);
      end
      pll_locked_async = 1'b1;
      step(15);
    end
    pll_locked_async = 1'b0;
    step(2);
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    checks++;
    if (lock_loss_cnt !== 8'd0 || domain_rst !== 3'b111) begin
      failures++;
      $display("FAIL clear_wins got=%0d/%b exp=0/111", lock_loss_cnt, domain_rst);
    end
    pll_locked_async = 1'b1;
    step(15);
    checks++;
    if (all_released !== 1'b1) begin failures++; $display("FAIL clear_relock got=%b exp=1", all_released); end
  endtask

  task automatic test_sw_reset_and_rst();
    pll_locked_async = 1'b0;
    step(3);
    pll_locked_async = 1'b1;
    step(15);
    checks++;
    if (all_released !== 1'b1 || lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL sw_pre got=%b/%0d exp=1/1", all_released, lock_loss_cnt);
    end
    sw_pll_reset = 1'b1;
    step(1);
    sw_pll_reset = 1'b0;
    checks++;
    if (pll_rst !== 1'b1 || domain_rst !== 3'b111 || all_released !== 1'b0 || lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL sw_enter got=%b/%b/%b/%0d exp=1/111/0/1", pll_rst, domain_rst, all_released, lock_loss_cnt);
    end
    for (int s = 2; s <= 5; s++) begin
      if (s == 2) sw_pll_reset = 1'b1;
      step(1);
      sw_pll_reset = 1'b0;
      checks++;
      if (pll_rst !== (s < 5)) begin
        failures++;
        $display("FAIL sw_pulse edge=%0d got=%b exp=%b", s, pll_rst, (s < 5));
      end
    end
    step(9);
    checks++;
    if (domain_rst !== 3'b110) begin failures++; $display("FAIL sw_relock got=%b exp=110", domain_rst); end
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (pll_rst !== 1'b1 || domain_rst !== 3'b111 || all_released !== 1'b0 || lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_release_rst got=%b/%b/%b/%0d exp=1/111/0/0", pll_rst, domain_rst, all_released, lock_loss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_staged_release();
    test_lock_timeout();
    test_stabilize_glitch();
    test_lock_loss_run();
    test_saturation_and_clear();
    test_sw_reset_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
